// File: rtl/demodulator_frame_sync.sv
// -----------------------------------------------------------------------------
// demodulator_frame_sync
//   Slices the demodulator's signed soft-sample stream into bits by
//   integrate-and-dump, hunts for a fixed sync word, then packs the payload
//   bits that follow into PayloadWidth-bit words. One frame of FrameWords
//   words is emitted per sync hit.
//
// Ports
//   clk        clock, all state on posedge
//   reset      asynchronous active-low reset (0 = reset)
//   recv_val   sample valid from demodulator
//   recv_rdy   block can accept a sample (low while an output word is held)
//   recv_msg   signed two's-complement sample
//   send_val   output word valid
//   send_rdy   downstream accepts word
//   send_msg   payload word, first-received bit in MSB
//   send_last  qualifies send_msg: last word of the frame
//   locked     high while payload bits are being collected
// -----------------------------------------------------------------------------
module demodulator_frame_sync #(
  parameter int                   Width         = 32,
  parameter int                   SamplesPerBit = 8,
  parameter int                   SyncWidth     = 16,
  parameter logic [SyncWidth-1:0] SyncWord      = 16'hD391,
  parameter int                   PayloadWidth  = 8,
  parameter int                   FrameWords    = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    recv_val,
  output logic                    recv_rdy,
  input  logic [Width-1:0]        recv_msg,
  output logic                    send_val,
  input  logic                    send_rdy,
  output logic [PayloadWidth-1:0] send_msg,
  output logic                    send_last,
  output logic                    locked
);

  // Accumulator carries clog2(SPB) guard bits so a full bit of extreme
  // samples can never wrap.
  localparam int CntW  = $clog2(SamplesPerBit);
  localparam int AccW  = Width + CntW;
  localparam int BitW  = (PayloadWidth > 1) ? $clog2(PayloadWidth) : 1;
  localparam int WordW = (FrameWords > 1) ? $clog2(FrameWords) : 1;

  localparam logic [CntW-1:0]  CntLast  = CntW'(SamplesPerBit - 1);
  localparam logic [BitW-1:0]  BitLast  = BitW'(PayloadWidth - 1);
  localparam logic [WordW-1:0] WordLast = WordW'(FrameWords - 1);

  typedef enum logic [0:0] {
    SEARCH  = 1'b0,
    PAYLOAD = 1'b1
  } state_t;

  state_t                   state_r;
  logic signed [AccW-1:0]   acc_r;
  logic [CntW-1:0]          cnt_r;
  logic [SyncWidth-1:0]     sync_sh_r;
  logic [PayloadWidth-1:0]  pay_sh_r;
  logic [BitW-1:0]          bit_cnt_r;
  logic [WordW-1:0]         word_cnt_r;
  logic                     send_val_r;
  logic [PayloadWidth-1:0]  send_msg_r;
  logic                     send_last_r;
  logic                     locked_r;

  logic                     accept_s;
  logic signed [AccW-1:0]   sample_ext_s;
  logic signed [AccW-1:0]   sum_s;
  logic                     bit_s;
  logic                     bit_evt_s;
  logic [SyncWidth-1:0]     sync_next_s;
  logic [PayloadWidth-1:0]  pay_next_s;

  // A single output register: input stalls whenever a word is held, so the
  // ready path depends on registered state only.
  assign recv_rdy  = ~send_val_r;
  assign accept_s  = recv_val & ~send_val_r;
  assign bit_evt_s = accept_s & (cnt_r == CntLast);

  assign send_val  = send_val_r;
  assign send_msg  = send_msg_r;
  assign send_last = send_last_r;
  assign locked    = locked_r;

  // Running sum, bit decision and next shift-register values.
  always_comb begin
    sample_ext_s = {{CntW{recv_msg[Width-1]}}, recv_msg};
    sum_s        = acc_r + sample_ext_s;
    // A zero sum slices to 1: only the sign bit decides.
    bit_s        = ~sum_s[AccW-1];
    sync_next_s    = sync_sh_r << 1;
    sync_next_s[0] = bit_s;
    pay_next_s     = pay_sh_r << 1;
    pay_next_s[0]  = bit_s;
  end

  // Integrate-and-dump; bit phase is fixed from reset and runs in both states.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_r <= '0;
      cnt_r <= '0;
    end else if (accept_s) begin
      if (cnt_r == CntLast) begin
        acc_r <= '0;
        cnt_r <= '0;
      end else begin
        acc_r <= sum_s;
        cnt_r <= cnt_r + 1'b1;
      end
    end
  end

  // Sync hunt / payload packing FSM with registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= SEARCH;
      sync_sh_r   <= '0;
      pay_sh_r    <= '0;
      bit_cnt_r   <= '0;
      word_cnt_r  <= '0;
      send_val_r  <= 1'b0;
      send_msg_r  <= '0;
      send_last_r <= 1'b0;
      locked_r    <= 1'b0;
    end else begin
      // Handshake and word completion never coincide: no sample is accepted
      // while send_val is high.
      if (send_val_r && send_rdy) begin
        send_val_r <= 1'b0;
      end

      if (bit_evt_s) begin
        case (state_r)
          SEARCH: begin
            sync_sh_r <= sync_next_s;
            if (sync_next_s == SyncWord) begin
              state_r    <= PAYLOAD;
              locked_r   <= 1'b1;
              bit_cnt_r  <= '0;
              word_cnt_r <= '0;
              // Sync bits are never reused, so the next search starts clean.
              sync_sh_r  <= '0;
            end
          end

          PAYLOAD: begin
            pay_sh_r <= pay_next_s;
            if (bit_cnt_r == BitLast) begin
              send_val_r  <= 1'b1;
              send_msg_r  <= pay_next_s;
              send_last_r <= (word_cnt_r == WordLast);
              bit_cnt_r   <= '0;
              if (word_cnt_r == WordLast) begin
                word_cnt_r <= '0;
                state_r    <= SEARCH;
                locked_r   <= 1'b0;
              end else begin
                word_cnt_r <= word_cnt_r + 1'b1;
              end
            end else begin
              bit_cnt_r <= bit_cnt_r + 1'b1;
            end
          end

          default: begin
            state_r  <= SEARCH;
            locked_r <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_demodulator_frame_sync.sv
// -----------------------------------------------------------------------------
// tb_demodulator_frame_sync
//   Directed frames plus randomized traffic against a sample/bit-level model:
//   bits are the sign of plain integer sums of SPB samples, sync is matched on
//   a sliding 16-bit window, payload words are built arithmetically.
// -----------------------------------------------------------------------------
module tb_demodulator_frame_sync;

  localparam int          SPB  = 8;
  localparam int          PW   = 8;
  localparam int          FW   = 4;
  localparam logic [15:0] SYNC = 16'hD391;

  logic        clk = 1'b0;
  logic        reset;
  logic        recv_val;
  logic        recv_rdy;
  logic [31:0] recv_msg;
  logic        send_val;
  logic        send_rdy;
  logic [7:0]  send_msg;
  logic        send_last;
  logic        locked;

  demodulator_frame_sync dut (
    .clk       (clk),
    .reset     (reset),
    .recv_val  (recv_val),
    .recv_rdy  (recv_rdy),
    .recv_msg  (recv_msg),
    .send_val  (send_val),
    .send_rdy  (send_rdy),
    .send_msg  (send_msg),
    .send_last (send_last),
    .locked    (locked)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // model state
  longint     m_sum;
  int         m_nsamp;
  logic       m_locked;
  int         m_hist;
  int         m_word;
  int         m_nbits;
  int         m_nwords;
  logic       e_val;
  logic [7:0] e_msg;
  logic       e_last;
  logic [7:0] obs[$];
  int         rdy_mode;   // 0 random, 1 always ready, 2 never ready

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_sum = 0; m_nsamp = 0; m_locked = 1'b0; m_hist = 0;
    m_word = 0; m_nbits = 0; m_nwords = 0;
    e_val = 1'b0; e_msg = 8'h00; e_last = 1'b0;
  endfunction

  function automatic void model_bit(input logic b);
    if (!m_locked) begin
      m_hist = ((m_hist << 1) | int'(b)) & 32'hFFFF;
      if (m_hist == int'(SYNC)) begin
        m_locked = 1'b1; m_hist = 0; m_word = 0; m_nbits = 0; m_nwords = 0;
      end
    end else begin
      m_word = m_word * 2 + int'(b);
      m_nbits++;
      if (m_nbits == PW) begin
        m_nwords++;
        e_val  = 1'b1;
        e_msg  = m_word[7:0];
        e_last = (m_nwords == FW);
        m_word = 0; m_nbits = 0;
        if (m_nwords == FW) m_locked = 1'b0;
      end
    end
  endfunction

  function automatic void model_sample(input logic [31:0] s);
    logic b;
    m_sum += longint'($signed(s));
    m_nsamp++;
    if (m_nsamp == SPB) begin
      b = (m_sum >= 0);
      m_sum = 0; m_nsamp = 0;
      model_bit(b);
    end
  endfunction

  // One clock: drive at negedge, check, advance to next negedge, check.
  task automatic step(input logic v, input logic [31:0] s, output logic acc);
    logic r;
    case (rdy_mode)
      0:       r = (($urandom % 3) != 0);
      1:       r = 1'b1;
      default: r = 1'b0;
    endcase
    recv_val = v; recv_msg = s; send_rdy = r;
    chk("recv_rdy", 32'(recv_rdy), 32'(!e_val));
    if (e_val) begin
      chk("send_msg", 32'(send_msg), 32'(e_msg));
      chk("send_last", 32'(send_last), 32'(e_last));
    end
    acc = v && !e_val;
    if (e_val && r) begin
      obs.push_back(send_msg);
      e_val = 1'b0;
    end
    if (acc) model_sample(s);
    @(posedge clk);
    @(negedge clk);
    chk("send_val", 32'(send_val), 32'(e_val));
    chk("locked", 32'(locked), 32'(m_locked));
  endtask

  task automatic send_sample(input logic [31:0] s);
    logic a;
    int   tries;
    tries = 0;
    a = 1'b0;
    while (!a && tries < 200) begin
      step((($urandom % 4) != 0), s, a);
      tries++;
    end
    if (!a) chk("sample_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_bit(input logic b);
    for (int i = 0; i < SPB; i++) send_sample(b ? 32'd100 : -32'sd100);
  endtask

  task automatic send_bits(input logic [31:0] val, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(val[i]);
  endtask

  task automatic send_bit_rand(input logic b);
    int amp;
    for (int i = 0; i < SPB; i++) begin
      amp = int'($urandom_range(5000, 1));
      if (($urandom % 8) == 0) send_sample($urandom);
      else send_sample(b ? 32'(amp) : 32'(-amp));
    end
  endtask

  task automatic drain();
    logic a;
    int   t;
    t = 0;
    while (e_val && t < 100) begin
      step(1'b0, 32'd0, a);
      t++;
    end
    if (e_val) chk("drain_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_frame(input string tag, input logic [7:0] w0, input logic [7:0] w1,
                             input logic [7:0] w2, input logic [7:0] w3);
    chk({tag, "_count"}, 32'(obs.size()), 32'd4);
    if (obs.size() == 4) begin
      chk({tag, "_w0"}, 32'(obs[0]), 32'(w0));
      chk({tag, "_w1"}, 32'(obs[1]), 32'(w1));
      chk({tag, "_w2"}, 32'(obs[2]), 32'(w2));
      chk({tag, "_w3"}, 32'(obs[3]), 32'(w3));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_send_val"}, 32'(send_val), 32'd0);
    chk({tag, "_send_msg"}, 32'(send_msg), 32'd0);
    chk({tag, "_send_last"}, 32'(send_last), 32'd0);
    chk({tag, "_locked"}, 32'(locked), 32'd0);
    chk({tag, "_recv_rdy"}, 32'(recv_rdy), 32'd1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        a;
    logic [31:0] rw;
    int pa[8] = '{3, -3, 5, -5, 1, -1, 0, 0};
    int pb[8] = '{-1, -1, -1, -1, -1, -1, -1, 6};
    logic [7:0] ext_bits;

    reset = 1'b0; recv_val = 1'b0; recv_msg = 32'd0; send_rdy = 1'b0;
    rdy_mode = 1;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b1;

    // 1: clean frame, always ready
    obs.delete();
    send_bits(32'(SYNC), 16);
    chk("t1_locked_on_sync", 32'(locked), 32'd1);
    send_bits(32'hA5, 8);
    send_bits(32'h3C, 8);
    send_bits(32'h00, 8);
    send_bits(32'hFF, 8);
    chk("t1_unlocked_after_last", 32'(locked), 32'd0);
    chk("t1_last_flag", 32'(send_last), 32'd1);
    drain();
    check_frame("t1", 8'hA5, 8'h3C, 8'h00, 8'hFF);

    // 2: near-miss sync must not lock
    obs.delete();
    send_bits(32'hD390, 16);
    chk("t2_no_lock_near_miss", 32'(locked), 32'd0);
    send_bits(32'(SYNC), 16);
    chk("t2_lock_after_sync", 32'(locked), 32'd1);
    send_bits(32'h12345678, 32);
    drain();
    check_frame("t2", 8'h12, 8'h34, 8'h56, 8'h78);

    // 3: back-pressure held for 5 cycles on word 3C
    obs.delete();
    send_bits(32'(SYNC), 16);
    send_bits(32'hA5, 8);
    send_bits(32'h3C, 8);
    rdy_mode = 2;
    chk("t3_pending", 32'(send_val), 32'd1);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 32'd100, a);
      chk("t3_hold_msg", 32'(send_msg), 32'h3C);
      chk("t3_hold_rdy", 32'(recv_rdy), 32'd0);
    end
    rdy_mode = 1;
    send_bits(32'h00, 8);
    send_bits(32'hFF, 8);
    drain();
    check_frame("t3", 8'hA5, 8'h3C, 8'h00, 8'hFF);

    // 4: zero-sum bit slices to 1, small negative sum to 0
    obs.delete();
    rdy_mode = 0;
    send_bits(32'(SYNC), 16);
    for (int i = 0; i < SPB; i++) send_sample(32'(pa[i]));
    for (int i = 0; i < SPB; i++) send_sample(32'(pb[i]));
    send_bits(32'h2A, 6);
    rw = $urandom;
    send_bits(rw, 24);
    drain();
    check_frame("t4", 8'hAA, rw[23:16], rw[15:8], rw[7:0]);

    // 5: extreme samples, no accumulator wrap
    obs.delete();
    send_bits(32'(SYNC), 16);
    ext_bits = 8'h65;
    for (int k = 7; k >= 0; k--)
      for (int i = 0; i < SPB; i++)
        send_sample(ext_bits[k] ? 32'h7FFF_FFFF : 32'h8000_0000);
    send_bits(32'h00C3_5A81, 24);
    drain();
    check_frame("t5", 8'h65, 8'hC3, 8'h5A, 8'h81);

    // 6: reset with the second word pending, then a full frame
    rdy_mode = 1;
    send_bits(32'(SYNC), 16);
    send_bits(32'hA5, 8);
    send_bits(32'h3C, 8);
    rdy_mode = 2;
    step(1'b0, 32'd0, a);
    chk("t6_pending_before_reset", 32'(send_val), 32'd1);
    reset = 1'b0;
    #1;
    check_reset_outputs("t6_async");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_reset_outputs("t6_hold");
    end
    model_reset();
    rdy_mode = 1;
    reset = 1'b1;
    obs.delete();
    send_bits(32'(SYNC), 16);
    send_bits(32'hA53C00FF, 32);
    drain();
    check_frame("t6", 8'hA5, 8'h3C, 8'h00, 8'hFF);

    // randomized traffic, checked cycle by cycle against the model
    rdy_mode = 0;
    for (int f = 0; f < 8; f++) begin
      int nb;
      nb = int'($urandom_range(24, 0));
      for (int i = 0; i < nb; i++) send_bit_rand(1'($urandom));
      if (($urandom % 4) != 0) begin
        for (int i = 15; i >= 0; i--) send_bit_rand(SYNC[i]);
        for (int i = 0; i < 32; i++) send_bit_rand(1'($urandom));
      end
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
